// File: rtl/regfile_sb.sv
// Architectural register file with two bypassed combinational read ports and a
// per-register pending-write scoreboard used by ctrl for RAW stall detection.
module regfile_sb #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              flush,
    output logic              sb_empty
);

    logic [DATA_W-1:0] regs [1:NREG-1];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;
    logic [DATA_W-1:0] arr_data1;
    logic [DATA_W-1:0] arr_data2;
    logic              arr_pend1;
    logic              arr_pend2;

    // Register array; writes to x0 fall outside the loop and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 1; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (we && (waddr == ADDR_W'(r))) begin
                    regs[r] <= wdata;
                end
            end
        end
    end

    // Flush clears everything; otherwise a new issue outranks a same-cycle write-back.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (issue_valid && (issue_rd == ADDR_W'(r))) begin
                    pending_nxt[r] = 1'b1;
                end else if (we && (waddr == ADDR_W'(r))) begin
                    pending_nxt[r] = 1'b0;
                end
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Array lookup for both ports, before bypass and gating.
    always_comb begin
        arr_data1 = '0;
        arr_data2 = '0;
        arr_pend1 = 1'b0;
        arr_pend2 = 1'b0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (raddr1 == ADDR_W'(r)) begin
                arr_data1 = regs[r];
                arr_pend1 = pending[r];
            end
            if (raddr2 == ADDR_W'(r)) begin
                arr_data2 = regs[r];
                arr_pend2 = pending[r];
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        rdata2 = '0;
        busy2  = 1'b0;
        if (rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = arr_data1;
                busy1  = arr_pend1;
            end
        end
        if (rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = arr_data2;
                busy2  = arr_pend2;
            end
        end
    end

    assign sb_empty = (pending == '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb against a behavioural model of
// the register contents and outstanding-write set.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        busy1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        busy2;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        sb_empty;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .busy1(busy1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .busy2(busy2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Architectural effect of one clock edge, from the inputs present at it.
    function automatic void model_edge();
        if (!rst) return;
        if (we && waddr != 0) m_regs[waddr] = wdata;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (we && waddr != 0) m_pend[waddr] = 1'b0;
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
    endfunction

    function automatic void model_read(input logic re, input logic [4:0] ra,
                                       output logic [31:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (!rst || !re || ra == 0) return;
        if (we && waddr == ra) begin
            d = wdata;
        end else begin
            d = m_regs[ra];
            b = m_pend[ra];
        end
    endfunction

    function automatic logic model_empty();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle_inputs();
        we = 0; waddr = 0; wdata = 0; issue_valid = 0; issue_rd = 0; flush = 0;
    endtask

    // Advance past the next rising edge, updating the model, and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        we = 1; waddr = 5; wdata = 32'hDEADBEEF; issue_valid = 1; issue_rd = 6;
        tick();
        idle_inputs();
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 6;
        #1;
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reset_prewrite: got %h want deadbeef", rdata1);
        end
        checks++;
        if (busy2 !== 1'b1 || sb_empty !== 1'b0) begin
            errors++; $display("FAIL reset_prepend: busy2=%b sb_empty=%b want 1 0", busy2, sb_empty);
        end
        #1;
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (rdata1 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0 || sb_empty !== 1'b1) begin
            errors++; $display("FAIL reset_async: rdata1=%h busy1=%b busy2=%b sb_empty=%b want 0 0 0 1",
                               rdata1, busy1, busy2, sb_empty);
        end
        we = 1; waddr = 5; wdata = 32'h11111111; issue_valid = 1; issue_rd = 5;
        tick();
        idle_inputs();
        rst = 1;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0 || sb_empty !== 1'b1) begin
            errors++; $display("FAIL reset_release: rdata1=%h busy1=%b busy2=%b sb_empty=%b want 0 0 0 1",
                               rdata1, busy1, busy2, sb_empty);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 1; waddr = 3; wdata = 32'h12345678; re1 = 1; raddr1 = 3;
        #1;
        checks++;
        if (rdata1 !== 32'h12345678 || busy1 !== 1'b0) begin
            errors++; $display("FAIL bypass_same_cycle: rdata1=%h busy1=%b want 12345678 0", rdata1, busy1);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rdata1 !== 32'h12345678) begin
            errors++; $display("FAIL write_read_array: rdata1=%h want 12345678", rdata1);
        end
        re1 = 0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++; $display("FAIL read_disabled: rdata1=%h want 0", rdata1);
        end
        re1 = 1;
    endtask

    task automatic test_x0();
        idle_inputs();
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0;
        re2 = 1; raddr2 = 0;
        #1;
        checks++;
        if (rdata2 !== 32'h0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL x0_same_cycle: rdata2=%h busy2=%b want 0 0", rdata2, busy2);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rdata2 !== 32'h0 || busy2 !== 1'b0 || sb_empty !== 1'b1) begin
            errors++; $display("FAIL x0_after: rdata2=%h busy2=%b sb_empty=%b want 0 0 1", rdata2, busy2, sb_empty);
        end
    endtask

    task automatic test_lifecycle();
        idle_inputs();
        re1 = 1; raddr1 = 7; issue_valid = 1; issue_rd = 7;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("FAIL issue_own_cycle: busy1=%b want 0", busy1);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (busy1 !== 1'b1 || sb_empty !== 1'b0) begin
                errors++; $display("FAIL pending_hold[%0d]: busy1=%b sb_empty=%b want 1 0", c, busy1, sb_empty);
            end
            tick();
        end
        we = 1; waddr = 7; wdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (busy1 !== 1'b0 || rdata1 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL writeback_cycle: busy1=%b rdata1=%h want 0 cafef00d", busy1, rdata1);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy1 !== 1'b0 || sb_empty !== 1'b1 || rdata1 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL after_writeback: busy1=%b sb_empty=%b rdata1=%h want 0 1 cafef00d",
                               busy1, sb_empty, rdata1);
        end
    endtask

    task automatic test_set_clear();
        idle_inputs();
        issue_valid = 1; issue_rd = 9;
        tick();
        idle_inputs();
        we = 1; waddr = 9; wdata = 32'h0000A5A5; issue_valid = 1; issue_rd = 9;
        re2 = 1; raddr2 = 9;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy2 !== 1'b1 || rdata2 !== 32'h0000A5A5) begin
            errors++; $display("FAIL set_beats_clear: busy2=%b rdata2=%h want 1 0000a5a5", busy2, rdata2);
        end
        we = 1; waddr = 9; wdata = 32'h0000A5A6;
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        logic [4:0] regs_l [4];
        regs_l[0] = 4; regs_l[1] = 10; regs_l[2] = 31; regs_l[3] = 12;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_rd = regs_l[i];
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (sb_empty !== 1'b0) begin
            errors++; $display("FAIL preflush_empty: sb_empty=%b want 0", sb_empty);
        end
        flush = 1; issue_valid = 1; issue_rd = 12; we = 1; waddr = 4; wdata = 32'h0BADCAFE;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            re1 = 1; raddr1 = regs_l[i];
            #1;
            checks++;
            if (busy1 !== 1'b0) begin
                errors++; $display("FAIL flush_busy x%0d: busy1=%b want 0", regs_l[i], busy1);
            end
        end
        raddr1 = 4;
        #1;
        checks++;
        if (sb_empty !== 1'b1 || rdata1 !== 32'h0BADCAFE) begin
            errors++; $display("FAIL flush_state: sb_empty=%b rdata1(x4)=%h want 1 0badcafe", sb_empty, rdata1);
        end
    endtask

    task automatic test_random();
        logic [31:0] ed1, ed2;
        logic        eb1, eb2;
        for (int n = 0; n < 400; n++) begin
            we          = ($urandom_range(0, 99) < 50);
            waddr       = 5'($urandom_range(0, 31));
            wdata       = $urandom;
            issue_valid = ($urandom_range(0, 99) < 45);
            issue_rd    = 5'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 99) < 4);
            re1         = ($urandom_range(0, 99) < 90);
            re2         = ($urandom_range(0, 99) < 90);
            raddr1      = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2      = ($urandom_range(0, 7) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            #1;
            model_read(re1, raddr1, ed1, eb1);
            model_read(re2, raddr2, ed2, eb2);
            checks++;
            if (rdata1 !== ed1 || busy1 !== eb1 || rdata2 !== ed2 || busy2 !== eb2
                || sb_empty !== model_empty()) begin
                errors++;
                $display("FAIL random[%0d]: p1=%h/%b p2=%h/%b empty=%b want p1=%h/%b p2=%h/%b empty=%b",
                         n, rdata1, busy1, rdata2, busy2, sb_empty, ed1, eb1, ed2, eb2, model_empty());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        test_reset();
        test_bypass();
        test_x0();
        test_lifecycle();
        test_set_clear();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Architectural integer register file with a pending-write scoreboard, sitting at the consumer end of the MEM/WB pipeline register. Accepts the write-back triple (destination, write enable, data) at each rising clock edge and serves two combinational read ports to the ID stage with same-cycle write-back bypass. A per-register pending bit is set when ID issues an instruction with a destination and cleared when that register is written back. The ctrl block uses the resulting busy flags to raise stall requests on RAW hazards.

## Interface
Parameters:
- ADDR_W, 5, register address width (`RegAddrBus`)
- DATA_W, 32, register data width (`RegBus`)
- NREG, 32, number of registers; x0 hardwired to zero

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- we  in  1  write enable from MEM/WB (`wb_wreg`)
- waddr  in  ADDR_W  write destination (`wb_wd`)
- wdata  in  DATA_W  write data (`wb_wdata`)
- re1  in  1  read port 1 enable
- raddr1  in  ADDR_W  read port 1 address
- rdata1  out  DATA_W  read port 1 data, combinational
- busy1  out  1  register on port 1 has an outstanding write
- re2, raddr2, rdata2, busy2  same as port 1, for port 2
- issue_valid  in  1  ID issues an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of the issuing instruction
- flush  in  1  discard all pending bits (pipeline redirect)
- sb_empty  out  1  no pending bits set

## Operation
- Storage: regs[1..NREG-1], DATA_W each; pending[1..NREG-1]. Index 0 has no storage: reads as 0, never pending.
- Write: at posedge, if we=1 and waddr!=0, regs[waddr] <= wdata. we=1 with waddr=0 is discarded.
- Read port n (1 or 2), priority order:
  - rst=0, re_n=0, or raddr_n=0 -> rdata_n=0, busy_n=0.
  - we=1 and waddr==raddr_n -> rdata_n=wdata (bypass), busy_n=0.
  - else -> rdata_n=regs[raddr_n], busy_n=pending[raddr_n].
- Pending update at posedge, per register r!=0:
  - flush=1 -> pending[r] <= 0 for all r. Issue and write-back in the same cycle are ignored for scoreboard purposes. A register write still occurs.
  - else if issue_valid=1 and issue_rd==r -> pending[r] <= 1. Set wins over a same-cycle write-back clear to the same r, because the new instruction owns the register.
  - else if we=1 and waddr==r -> pending[r] <= 0.
  - issue_rd=0 never sets a bit.
- Busy reflects the pre-edge state. An instruction issuing in cycle t does not see its own destination as busy on its source reads in cycle t.
- sb_empty = (pending == 0), combinational from state.
- Both read ports are fully independent; identical addresses on both ports return identical data and busy.

## Timing
- Reset: asynchronous on rst falling. All regs = 0, all pending = 0 immediately. While rst=0: rdata1/2=0, busy1/2=0, sb_empty=1. Writes and issues are ignored.
- Reset deasserts synchronously to the design; the first state update is at the first posedge with rst=1.
- Write latency: data written at edge t is visible from the array in cycle t+1. Via bypass it is visible in cycle t, before the edge.
- Pending latency: issue at edge t -> busy from cycle t+1. Write-back at edge t -> busy=0 in cycle t via bypass, and cleared state from t+1.
- No handshake; every input is sampled on every edge. Upstream holds we=0 during stalls (MEM/WB inserts bubbles).
- Reset mid-operation: all state lost, including pending bits. No write in the reset cycle completes.

## Test plan
- Reset: write 0xDEADBEEF to x5, then assert rst=0 mid-cycle -> rdata1 (raddr1=5, re1=1) reads 0 immediately and after release; sb_empty=1.
- Write/read and bypass: we=1, waddr=3, wdata=0x12345678, raddr1=3 in the same cycle -> rdata1=0x12345678 before the edge. The next cycle with we=0 also reads 0x12345678.
- x0 rules: we=1, waddr=0, wdata=0xFFFFFFFF; issue_valid=1, issue_rd=0 -> rdata2 (raddr2=0)=0, busy2=0, sb_empty stays 1.
- Scoreboard lifecycle: issue rd=7 -> busy1=1 for raddr1=7 from the next cycle until the write-back cycle (busy1=0 and bypass data in that cycle). sb_empty returns to 1 after the edge.
- Simultaneous set/clear: pending[9]=1, then the same cycle has we=1, waddr=9 and issue_valid=1, issue_rd=9 -> after the edge busy=1 for x9 and regs[9]=wdata.
- Flush: pending set for x4, x10, x31; flush=1 together with issue_rd=12 -> after the edge all busy=0, sb_empty=1, x12 not pending.
